// File: rtl/sum_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
//   state_e    : sequencer states
//   DEF_N      : default operand width
//   DEF_CC     : default cycles per operation
//   DEF_W      : default chunk width (DEF_N / DEF_CC)
//   cnt_w()    : chunk counter width, $clog2(cc) but never below 1
package sum_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_N  = 128;
  localparam int DEF_CC = 64;
  localparam int DEF_W  = DEF_N / DEF_CC;

  function automatic int cnt_w(input int cc);
    return (cc <= 1) ? 1 : $clog2(cc);
  endfunction

endpackage

// File: rtl/serial_addsub_slice.sv
// Combinational W-bit ripple slice of the serial adder/subtractor.
// In subtract mode b is inverted here; the +1 of the two's complement is
// supplied by the caller through cin on the first chunk.
//   a, b      in  W  operand chunks
//   cin       in  1  carry into bit 0
//   sub       in  1  1 = invert b
//   r         out W  sum chunk
//   cout      out 1  carry out of the MSB
//   c_msb_in  out 1  carry into the MSB (only built when SUM_OVF_EN is defined)
module serial_addsub_slice
  import sum_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] r,
  output logic         cout
`ifdef SUM_OVF_EN
  ,
  output logic         c_msb_in
`endif
);

  logic [W-1:0] b_x;

  always_comb begin
    b_x = b ^ {W{sub}};
    {cout, r} = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, cin};
  end

`ifdef SUM_OVF_EN
  // sum bit = a ^ b ^ carry_in, so the MSB carry-in falls out of the result bit.
  assign c_msb_in = r[W-1] ^ a[W-1] ^ b_x[W-1];
`endif

endmodule

// File: rtl/serial_addsub_n.sv
// Bit-serial N-bit adder/subtractor: one operation spans CC cycles, W = N/CC
// bits per cycle, least significant chunk first. The inter-chunk carry lives
// in a register, so the combinational path is only W bits wide.
// Optional feature macro: SUM_OVF_EN adds the signed-overflow output ovf.
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous reset, active-low
//   start    in   1  begin an operation; chunk 0 of a/b sampled this cycle
//   sub      in   1  mode sampled with start: 0 = a+b, 1 = a-b
//   a, b     in   W  operand chunks for the current cycle
//   c        out  W  registered result chunk
//   c_valid  out  1  c holds a valid chunk
//   busy     out  1  operation in progress (cycle after start .. last chunk sampled)
//   done     out  1  one-cycle pulse with the last valid chunk
//   cout     out  1  final carry while done=1 (sub: 1 = no borrow)
//   ovf      out  1  signed overflow while done=1 (SUM_OVF_EN only)
//
// state | meaning
// IDLE  | waiting for start; a start here processes chunk 0
// RUN   | processing chunk cnt_q each cycle, until chunk CC-1
module serial_addsub_n
  import sum_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int CC = DEF_CC,
  localparam int W  = N / CC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic         c_valid,
  output logic         busy,
  output logic         done,
  output logic         cout
`ifdef SUM_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int                CNT_W    = cnt_w(CC);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CC - 1);

  if (CC < 1 || (N % CC) != 0) begin : g_bad_cfg
    $error("serial_addsub_n: N must be a positive multiple of CC");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               sub_q, sub_d;
  logic [W-1:0]       c_q, c_d;
  logic               c_valid_q, c_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;

  logic               is_idle;
  logic               active;
  logic               last;
  logic               s_cur;
  logic               cin;
  logic [W-1:0]       r;
  logic               cy;

`ifdef SUM_OVF_EN
  logic               ovf_q, ovf_d;
  logic               c_msb_in;
`endif

  serial_addsub_slice #(
    .W (W)
  ) u_slice (
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (s_cur),
    .r        (r),
    .cout     (cy)
`ifdef SUM_OVF_EN
    ,
    .c_msb_in (c_msb_in)
`endif
  );

  always_comb begin
    is_idle = (state_q == IDLE);
    // In IDLE a start launches chunk 0; in RUN every cycle is a chunk and
    // a stray start is simply ignored.
    active  = is_idle ? start : 1'b1;
    // Mode comes straight from the port on chunk 0, from the latch afterwards.
    s_cur   = is_idle ? sub : sub_q;
    // Chunk 0 carries in the +1 of the two's complement when subtracting.
    cin     = is_idle ? sub : carry_q;
    // cnt_q is 0 in IDLE, so CC==1 finishes on the start cycle itself.
    last    = active && (cnt_q == LAST_CNT);

    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sub_d     = (is_idle && start) ? sub : sub_q;
    c_d       = c_q;
    if (active) begin
      c_d = r;
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
        carry_d = 1'b0;
      end else begin
        state_d = RUN;
        cnt_d   = cnt_q + CNT_W'(1);
        carry_d = cy;
      end
    end
    c_valid_d = active;
    busy_d    = active && !last;
    done_d    = last;
    cout_d    = last && cy;
`ifdef SUM_OVF_EN
    ovf_d     = last && (c_msb_in ^ cy);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      c_q       <= '0;
      c_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
`ifdef SUM_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      sub_q     <= sub_d;
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cout_q    <= cout_d;
`ifdef SUM_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign c       = c_q;
  assign c_valid = c_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cout    = cout_q;
`ifdef SUM_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_n.sv
// Directed bench for serial_addsub_n: a 128-bit / 64-cycle instance and an
// 8-bit / 1-cycle instance share clock and reset. Build with +define+SUM_OVF_EN
// to include the overflow scenarios.
module tb_serial_addsub_n;

  localparam int N   = 128;
  localparam int CC  = 64;
  localparam int W   = 2;
  localparam int N1  = 8;
  localparam int CC1 = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic         start, sub;
  logic [W-1:0] a, b, c;
  logic         c_valid, busy, done, cout;

  logic          start1, sub1;
  logic [N1-1:0] a1, b1, c1;
  logic          c_valid1, busy1, done1, cout1;

`ifdef SUM_OVF_EN
  logic ovf, ovf1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] op_res;
  logic         op_cout;
  int           op_valid;
  int           op_done_at;
  int           op_busy_bad;
`ifdef SUM_OVF_EN
  logic         op_ovf;
  int           op_ovf_stray;
`endif

  always #5 clk = ~clk;

  serial_addsub_n #(.N(N), .CC(CC)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .c       (c),
    .c_valid (c_valid),
    .busy    (busy),
    .done    (done),
    .cout    (cout)
`ifdef SUM_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  serial_addsub_n #(.N(N1), .CC(CC1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .sub     (sub1),
    .a       (a1),
    .b       (b1),
    .c       (c1),
    .c_valid (c_valid1),
    .busy    (busy1),
    .done    (done1),
    .cout    (cout1)
`ifdef SUM_OVF_EN
    ,
    .ovf     (ovf1)
`endif
  );

  function automatic logic [N:0] ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                        input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (N+1)'(1);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds one full operation chunk by chunk and collects what comes out.
  // With inject set, start pulses and a flipped mode are applied mid-op.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic s, input bit inject);
    op_res      = '0;
    op_cout     = 1'b0;
    op_valid    = 0;
    op_done_at  = -1;
    op_busy_bad = 0;
`ifdef SUM_OVF_EN
    op_ovf       = 1'b0;
    op_ovf_stray = 0;
`endif
    for (int k = 0; k < CC; k++) begin
      start = (k == 0) || (inject && (k % 16 == 5));
      sub   = (k == 0 || !inject) ? s : ~s;
      a     = av[W*k +: W];
      b     = bv[W*k +: W];
      step();
      if (c_valid) op_valid++;
      op_res[W*k +: W] = c;
      if (done) begin
        op_done_at = (op_done_at < 0) ? k : -2;
        op_cout    = cout;
      end
      if (k < CC - 1 && !busy) op_busy_bad++;
`ifdef SUM_OVF_EN
      if (done) op_ovf = ovf;
      else if (ovf) op_ovf_stray++;
`endif
    end
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
  endtask

  task automatic test_reset();
    logic [N-1:0] exp_res;
    int           stray_done;
    int           stray_valid;
    rst = 1'b0;
    #12;
    n_checks++;
    if ({c, c_valid, busy, done, cout} !== '0)
      $display("FAIL reset_values got c=%b c_valid=%b busy=%b done=%b cout=%b want all 0",
               c, c_valid, busy, done, cout);
    else n_pass++;
    rst = 1'b1;
    step();
    // Subtract 0-0 keeps the carry register at 1 while aborted.
    for (int k = 0; k < 10; k++) begin
      start = (k == 0);
      sub   = 1'b1;
      a     = '0;
      b     = '0;
      step();
    end
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy_before got %b want 1", busy);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy_after got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (c_valid !== 1'b0) $display("FAIL reset_cvalid_after got %b want 0", c_valid);
    else n_pass++;
    #2;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    stray_done  = 0;
    stray_valid = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done) stray_done++;
      if (c_valid) stray_valid++;
    end
    n_checks++;
    if (stray_done !== 0 || stray_valid !== 0)
      $display("FAIL reset_no_done got done=%0d valid=%0d want 0 0", stray_done, stray_valid);
    else n_pass++;
    exp_res = 128'h123456789ABCDF01_0FEDCBA987654321;
    run_op(128'h0123456789ABCDEF_FEDCBA9876543210, 128'h1111111111111111_1111111111111111,
           1'b0, 1'b0);
    n_checks++;
    if (op_res !== exp_res) $display("FAIL reset_clean_res got %h want %h", op_res, exp_res);
    else n_pass++;
    n_checks++;
    if (op_cout !== 1'b0) $display("FAIL reset_clean_cout got %b want 0", op_cout);
    else n_pass++;
    n_checks++;
    if (op_valid !== CC || op_done_at !== CC - 1)
      $display("FAIL reset_clean_frame got valid=%0d done_at=%0d want %0d %0d",
               op_valid, op_done_at, CC, CC - 1);
    else n_pass++;
  endtask

  task automatic test_add();
    run_op({N{1'b1}}, 128'd1, 1'b0, 1'b0);
    n_checks++;
    if (op_res !== '0) $display("FAIL add_wrap_res got %h want 0", op_res);
    else n_pass++;
    n_checks++;
    if (op_cout !== 1'b1) $display("FAIL add_wrap_cout got %b want 1", op_cout);
    else n_pass++;
    n_checks++;
    if (op_done_at !== CC - 1) $display("FAIL add_done_pos got %0d want %0d", op_done_at, CC - 1);
    else n_pass++;
    n_checks++;
    if (op_busy_bad !== 0 || op_valid !== CC)
      $display("FAIL add_frame got busy_bad=%0d valid=%0d want 0 %0d", op_busy_bad, op_valid, CC);
    else n_pass++;
    step();
    n_checks++;
    if (c_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL add_idle_after got c_valid=%b done=%b busy=%b want 0 0 0",
               c_valid, done, busy);
    else n_pass++;
  endtask

  task automatic test_sub();
    run_op(128'd5, 128'd7, 1'b1, 1'b0);
    n_checks++;
    if (op_res !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE)
      $display("FAIL sub_neg_res got %h want fff..fe", op_res);
    else n_pass++;
    n_checks++;
    if (op_cout !== 1'b0) $display("FAIL sub_neg_cout got %b want 0", op_cout);
    else n_pass++;
    run_op(128'd7, 128'd5, 1'b1, 1'b0);
    n_checks++;
    if (op_res !== 128'd2) $display("FAIL sub_pos_res got %h want 2", op_res);
    else n_pass++;
    n_checks++;
    if (op_cout !== 1'b1) $display("FAIL sub_pos_cout got %b want 1", op_cout);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] x0, y0, x1, y1;
    logic [N:0]   exp0, exp1;
    int           valid_total;
    x0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    y0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    x1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    y1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp0 = ref_op(x0, y0, 1'b0);
    exp1 = ref_op(x1, y1, 1'b1);
    run_op(x0, y0, 1'b0, 1'b1);
    valid_total = op_valid;
    n_checks++;
    if ({op_cout, op_res} !== exp0)
      $display("FAIL b2b_first got %b_%h want %b_%h", op_cout, op_res, exp0[N], exp0[N-1:0]);
    else n_pass++;
    // Second start lands in the cycle where done of the first is high.
    run_op(x1, y1, 1'b1, 1'b1);
    valid_total += op_valid;
    n_checks++;
    if ({op_cout, op_res} !== exp1)
      $display("FAIL b2b_second got %b_%h want %b_%h", op_cout, op_res, exp1[N], exp1[N-1:0]);
    else n_pass++;
    n_checks++;
    if (valid_total !== 2 * CC || op_done_at !== CC - 1)
      $display("FAIL b2b_valid_run got valid=%0d done_at=%0d want %0d %0d",
               valid_total, op_done_at, 2 * CC, CC - 1);
    else n_pass++;
    step();
    n_checks++;
    if (c_valid !== 1'b0) $display("FAIL b2b_idle_after got %b want 0", c_valid);
    else n_pass++;
  endtask

  task automatic test_cc1();
    start1 = 1'b1;
    sub1   = 1'b0;
    a1     = 8'd200;
    b1     = 8'd100;
    step();
    n_checks++;
    if ({c1, c_valid1, done1, cout1} !== {8'd44, 1'b1, 1'b1, 1'b1})
      $display("FAIL cc1_add got c=%0d v=%b d=%b co=%b want 44 1 1 1", c1, c_valid1, done1, cout1);
    else n_pass++;
`ifdef SUM_OVF_EN
    n_checks++;
    if (ovf1 !== 1'b0) $display("FAIL cc1_add_ovf got %b want 0", ovf1);
    else n_pass++;
`endif
    sub1 = 1'b1;
    a1   = 8'd100;
    b1   = 8'd200;
    step();
    n_checks++;
    if ({c1, c_valid1, done1, cout1} !== {8'd156, 1'b1, 1'b1, 1'b0})
      $display("FAIL cc1_sub got c=%0d v=%b d=%b co=%b want 156 1 1 0", c1, c_valid1, done1, cout1);
    else n_pass++;
`ifdef SUM_OVF_EN
    n_checks++;
    if (ovf1 !== 1'b1) $display("FAIL cc1_sub_ovf got %b want 1", ovf1);
    else n_pass++;
`endif
    start1 = 1'b0;
    step();
    n_checks++;
    if (c_valid1 !== 1'b0 || done1 !== 1'b0)
      $display("FAIL cc1_idle got v=%b d=%b want 0 0", c_valid1, done1);
    else n_pass++;
  endtask

`ifdef SUM_OVF_EN
  task automatic test_ovf();
    run_op({1'b0, {(N-1){1'b1}}}, 128'd1, 1'b0, 1'b0);
    n_checks++;
    if (op_ovf !== 1'b1 || op_ovf_stray !== 0)
      $display("FAIL ovf_add got ovf=%b stray=%0d want 1 0", op_ovf, op_ovf_stray);
    else n_pass++;
    run_op({1'b1, {(N-1){1'b0}}}, 128'd1, 1'b1, 1'b0);
    n_checks++;
    if (op_ovf !== 1'b1 || op_cout !== 1'b1)
      $display("FAIL ovf_sub got ovf=%b cout=%b want 1 1", op_ovf, op_cout);
    else n_pass++;
    run_op(128'd3, 128'd4, 1'b1, 1'b0);
    n_checks++;
    if (op_ovf !== 1'b0 || op_res !== {N{1'b1}})
      $display("FAIL ovf_none got ovf=%b res=%h want 0 fff..f", op_ovf, op_res);
    else n_pass++;
  endtask
`endif

  initial begin
    start  = 1'b0;
    sub    = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    sub1   = 1'b0;
    a1     = '0;
    b1     = '0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_cc1();
`ifdef SUM_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
